// File: rtl/adder_station_pkg.sv
// Shared constants for the adder reservation station: bus widths, opcodes,
// instruction field positions, FSM state encoding and small decode helpers.
package adder_station_pkg;

    localparam int WORD_SIZE = 32;
    localparam int RB_SIZE   = 8;
    localparam int RB_INDEX  = 3;
    localparam int REG_INDEX = 4;
    localparam int FU_INDEX  = 4;

    localparam logic [RB_INDEX-1:0] READY = '0;
    localparam logic [FU_INDEX-1:0] NO_FU = '1;

    localparam logic [3:0] INST_ADD  = 4'h1;
    localparam logic [3:0] INST_SUB  = 4'h2;
    localparam logic [3:0] INST_ADDI = 4'h3;
    localparam logic [3:0] INST_SUBI = 4'h4;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS_MSB  = 23;
    localparam int RS_LSB  = 20;
    localparam int RT_MSB  = 19;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OPS = 2'd1,
        ST_EXEC     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    function automatic logic is_adder_op(input logic [3:0] op);
        return (op == INST_ADD) || (op == INST_SUB) || (op == INST_ADDI) || (op == INST_SUBI);
    endfunction

    function automatic logic is_imm_op(input logic [3:0] op);
        return (op == INST_ADDI) || (op == INST_SUBI);
    endfunction

    function automatic logic [WORD_SIZE-1:0] sext_imm(input logic [15:0] imm);
        return {{(WORD_SIZE-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/adder_station_operand.sv
// One source operand of the station: tag, value and ready flag, resolved from
// the register file or by snooping the result bus. ADDER_STATION_BYPASS_EN
// also lets an operand be captured from the bus on the issue edge itself.
module operand_slot
    import adder_station_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          load,
    input  logic [RB_INDEX-1:0]           load_q,
    input  logic [WORD_SIZE-1:0]          load_v,
    input  logic [RB_SIZE*WORD_SIZE-1:0]  snoop_data,
    input  logic [RB_SIZE-1:0]            snoop_valid,
    output logic                          ready_now,
    output logic                          bypass_ready,
    output logic signed [WORD_SIZE-1:0]   value
);

    logic [RB_INDEX-1:0]  q;
    logic                 ready;
    logic                 capture;
    logic                 load_hit;
    logic [WORD_SIZE-1:0] snoop_now;
    logic [WORD_SIZE-1:0] snoop_load;

    assign snoop_now  = snoop_data[int'(q)*WORD_SIZE +: WORD_SIZE];
    assign snoop_load = snoop_data[int'(load_q)*WORD_SIZE +: WORD_SIZE];

    // A pending operand (tag not READY) is taken from its slot the first time it is valid.
    assign capture   = !ready && (q != READY) && snoop_valid[q];
    assign ready_now = ready || capture;

`ifdef ADDER_STATION_BYPASS_EN
    assign load_hit     = (load_q != READY) && snoop_valid[load_q];
    assign bypass_ready = (load_q == READY) || load_hit;
`else
    assign load_hit     = 1'b0;
    assign bypass_ready = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= READY;
            ready <= 1'b0;
        end else if (flush) begin
            q     <= READY;
            ready <= 1'b0;
        end else if (load) begin
            q     <= load_q;
            ready <= (load_q == READY) || load_hit;
        end else if (capture) begin
            ready <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load && !flush) begin
            value <= load_hit ? snoop_load : load_v;
        end else if (capture) begin
            value <= snoop_now;
        end
    end

endmodule

// File: rtl/adder_station.sv
// Reservation station plus ADD/SUB/ADDI/SUBI unit for one functional-unit slot.
// Optional ADDER_STATION_BYPASS_EN resolves operands on the issue edge.
module adder_station
    import adder_station_pkg::*;
#(
    parameter int FU_ID    = 0,
    parameter int EXEC_LAT = 2
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fu_reset,
    input  logic [FU_INDEX-1:0]           CDB_inst_fu,
    input  logic [WORD_SIZE-1:0]          CDB_inst_inst,
    input  logic [RB_INDEX-1:0]           CDB_inst_RBindex,
    output logic                          busy,
    output logic [REG_INDEX-1:0]          numj,
    output logic [REG_INDEX-1:0]          numk,
    input  logic [RB_INDEX-1:0]           qj,
    input  logic [RB_INDEX-1:0]           qk,
    input  logic [WORD_SIZE-1:0]          vj,
    input  logic [WORD_SIZE-1:0]          vk,
    input  logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_in,
    input  logic [RB_SIZE-1:0]            CDB_valid_in,
    output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data,
    output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
    output logic [RB_SIZE-1:0]            CDB_data_valid
);

    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_LAT - 1);

    state_t                       state, state_next;
    logic [CNT_W-1:0]             cnt, cnt_next;
    logic                         holding, holding_next;
    logic                         accept, finish;
    logic                         issue_ok, imm_form;
    logic [3:0]                   inst_op;
    logic [3:0]                   unused_rd;
    logic [RB_INDEX-1:0]          tag;
    logic                         is_sub;
    logic [RB_INDEX-1:0]          k_load_q;
    logic [WORD_SIZE-1:0]         k_load_v;
    logic                         j_ready_now, k_ready_now, j_bypass, k_bypass;
    logic signed [WORD_SIZE-1:0]  vj_op, vk_op, result;

    function automatic logic signed [WORD_SIZE-1:0] add_sub(
        input logic                        sub,
        input logic signed [WORD_SIZE-1:0] a,
        input logic signed [WORD_SIZE-1:0] b
    );
        return sub ? (a - b) : (a + b);
    endfunction

    assign inst_op   = CDB_inst_inst[OP_MSB:OP_LSB];
    assign unused_rd = CDB_inst_inst[RD_MSB:RD_LSB];
    assign numj      = CDB_inst_inst[RS_MSB:RS_LSB];
    assign numk      = CDB_inst_inst[RT_MSB:RT_LSB];
    assign imm_form  = is_imm_op(inst_op);

    assign busy     = (state == ST_WAIT_OPS) || (state == ST_EXEC);
    assign issue_ok = (CDB_inst_fu == FU_INDEX'(FU_ID)) && !busy && is_adder_op(inst_op);

    // Immediate forms present operand k as already resolved.
    assign k_load_q = imm_form ? READY : qk;
    assign k_load_v = imm_form ? sext_imm(CDB_inst_inst[IMM_MSB:IMM_LSB]) : vk;

    operand_slot slot_j (
        .clk          (clk),
        .reset        (reset),
        .flush        (fu_reset),
        .load         (accept),
        .load_q       (qj),
        .load_v       (vj),
        .snoop_data   (CDB_data_in),
        .snoop_valid  (CDB_valid_in),
        .ready_now    (j_ready_now),
        .bypass_ready (j_bypass),
        .value        (vj_op)
    );

    operand_slot slot_k (
        .clk          (clk),
        .reset        (reset),
        .flush        (fu_reset),
        .load         (accept),
        .load_q       (k_load_q),
        .load_v       (k_load_v),
        .snoop_data   (CDB_data_in),
        .snoop_valid  (CDB_valid_in),
        .ready_now    (k_ready_now),
        .bypass_ready (k_bypass),
        .value        (vk_op)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        holding_next = holding;
        accept       = 1'b0;
        finish       = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (issue_ok) begin
                    accept       = 1'b1;
                    holding_next = 1'b0;
                    if (j_bypass && k_bypass) begin
                        state_next = ST_EXEC;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = ST_WAIT_OPS;
                    end
                end
            end
            ST_WAIT_OPS: begin
                if (j_ready_now && k_ready_now) begin
                    state_next = ST_EXEC;
                    cnt_next   = CNT_LOAD;
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    finish       = 1'b1;
                    holding_next = 1'b1;
                    state_next   = ST_DONE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A flush overrides everything, including an issue on the same edge.
        if (fu_reset) begin
            state_next   = ST_IDLE;
            holding_next = 1'b0;
            accept       = 1'b0;
            finish       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            holding <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            holding <= holding_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag    <= CDB_inst_RBindex;
            is_sub <= (inst_op == INST_SUB) || (inst_op == INST_SUBI);
        end
        if (finish) begin
            result <= add_sub(is_sub, vj_op, vk_op);
        end
    end

    // Only the owned slot is driven; the top level OR-merges all stations.
    always_comb begin
        CDB_data_data  = '0;
        CDB_data_valid = '0;
        if (holding) begin
            CDB_data_valid[tag]                                 = 1'b1;
            CDB_data_data[int'(tag)*WORD_SIZE +: WORD_SIZE]     = result;
        end
    end

    assign CDB_data_addr = '0;

endmodule

// File: tb/tb_adder_station.sv
// Randomized self-checking bench for adder_station against an arithmetic/latency model.
module tb_adder_station;
    import adder_station_pkg::*;

    localparam int FU_ID    = 0;
    localparam int EXEC_LAT = 2;
    localparam int BUS_W    = RB_SIZE * WORD_SIZE;

    logic                  clk = 1'b0;
    logic                  reset, fu_reset;
    logic [FU_INDEX-1:0]   CDB_inst_fu;
    logic [WORD_SIZE-1:0]  CDB_inst_inst;
    logic [RB_INDEX-1:0]   CDB_inst_RBindex;
    logic                  busy;
    logic [REG_INDEX-1:0]  numj, numk;
    logic [RB_INDEX-1:0]   qj, qk;
    logic [WORD_SIZE-1:0]  vj, vk;
    logic [BUS_W-1:0]      CDB_data_in;
    logic [RB_SIZE-1:0]    CDB_valid_in;
    logic [BUS_W-1:0]      CDB_data_data, CDB_data_addr;
    logic [RB_SIZE-1:0]    CDB_data_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_station #(.FU_ID(FU_ID), .EXEC_LAT(EXEC_LAT)) dut (
        .clk(clk), .reset(reset), .fu_reset(fu_reset),
        .CDB_inst_fu(CDB_inst_fu), .CDB_inst_inst(CDB_inst_inst), .CDB_inst_RBindex(CDB_inst_RBindex),
        .busy(busy), .numj(numj), .numk(numk), .qj(qj), .qk(qk), .vj(vj), .vk(vk),
        .CDB_data_in(CDB_data_in), .CDB_valid_in(CDB_valid_in),
        .CDB_data_data(CDB_data_data), .CDB_data_addr(CDB_data_addr), .CDB_data_valid(CDB_data_valid)
    );

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [15:0] imm);
        logic [31:0] ext;
        ext = {{16{imm[15]}}, imm};
        case (op)
            INST_ADD:  return a + b;
            INST_SUB:  return a - b;
            INST_ADDI: return a + ext;
            default:   return a - ext;
        endcase
    endfunction

    // Result edge = edge at which the later operand arrives, then EXEC_LAT edges of execution.
    function automatic int model_latency(input logic [3:0] op, input logic [2:0] qj_t, input int dj,
                                         input logic [2:0] qk_t, input int dk);
        int cj, ck, r;
        cj = (qj_t == READY) ? 0 : dj;
        ck = (op == INST_ADDI || op == INST_SUBI || qk_t == READY) ? 0 : dk;
        r  = (cj > ck) ? cj : ck;
`ifndef ADDER_STATION_BYPASS_EN
        if (r < 1) r = 1;
`endif
        return r + EXEC_LAT;
    endfunction

    task automatic randomize_bus_data();
        for (int s = 0; s < RB_SIZE; s++) CDB_data_in[s*WORD_SIZE +: WORD_SIZE] = $urandom;
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [2:0] tag,
                           input logic [2:0] qj_t, input int dj, input logic [31:0] a,
                           input logic [2:0] qk_t, input int dk, input logic [31:0] b,
                           input logic [15:0] imm, input string name);
        logic [31:0]      exp_res;
        logic [BUS_W-1:0] exp_data;
        logic [7:0]       exp_valid;
        logic [3:0]       rs, rt;
        int               exp_lat, lat;
        bit               seen, imm_op;
        imm_op   = (op == INST_ADDI) || (op == INST_SUBI);
        exp_res  = model_result(op, a, b, imm);
        exp_lat  = model_latency(op, qj_t, dj, qk_t, dk);
        exp_data = '0;
        exp_data[int'(tag)*WORD_SIZE +: WORD_SIZE] = exp_res;
        exp_valid = 8'd1 << tag;
        rs = 4'($urandom);
        rt = 4'($urandom);
        @(negedge clk);
        CDB_inst_inst    = {op, 4'($urandom), rs, rt, imm};
        CDB_inst_fu      = FU_INDEX'(FU_ID);
        CDB_inst_RBindex = tag;
        qj = qj_t;
        qk = qk_t;
        vj = (qj_t == READY) ? a : $urandom;
        vk = (!imm_op && qk_t == READY) ? b : $urandom;
        CDB_valid_in = '0;
        randomize_bus_data();
        #1;
        checks++;
        if (numj !== rs || numk !== rt) begin
            errors++;
            $display("FAIL %s numj/numk: got %h/%h expected %h/%h", name, numj, numk, rs, rt);
        end
        @(negedge clk);
        CDB_inst_fu   = NO_FU;
        CDB_inst_inst = $urandom;
        checks++;
        if (busy !== 1'b1 || CDB_data_valid !== 8'h00) begin
            errors++;
            $display("FAIL %s accept: busy=%b valid=%h expected busy=1 valid=00", name, busy, CDB_data_valid);
        end
        seen = 0;
        lat  = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (CDB_data_valid !== 8'h00) begin
                seen = 1;
                lat  = c - 1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_hold cycle %0d: got %b expected 1", name, c, busy);
                end
                CDB_valid_in = '0;
                randomize_bus_data();
                if (qj_t != READY && dj == c) begin
                    CDB_valid_in[qj_t] = 1'b1;
                    CDB_data_in[int'(qj_t)*WORD_SIZE +: WORD_SIZE] = a;
                end
                if (!imm_op && qk_t != READY && dk == c) begin
                    CDB_valid_in[qk_t] = 1'b1;
                    CDB_data_in[int'(qk_t)*WORD_SIZE +: WORD_SIZE] = b;
                end
                @(negedge clk);
            end
        end
        CDB_valid_in = '0;
        checks++;
        if (!seen || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", name, lat, seen, exp_lat);
        end
        checks++;
        if (CDB_data_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s valid: got %h expected %h", name, CDB_data_valid, exp_valid);
        end
        checks++;
        if (CDB_data_data !== exp_data) begin
            errors++;
            $display("FAIL %s data: slot=%h expected %h (full bus differs)", name,
                     CDB_data_data[int'(tag)*WORD_SIZE +: WORD_SIZE], exp_res);
        end
        checks++;
        if (busy !== 1'b0 || CDB_data_addr !== '0) begin
            errors++;
            $display("FAIL %s done: busy=%b addr_nonzero=%b expected busy=0 addr=0", name, busy, |CDB_data_addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; fu_reset = 1'b0;
        CDB_inst_fu = NO_FU; CDB_inst_inst = '0; CDB_inst_RBindex = '0;
        qj = '0; qk = '0; vj = '0; vk = '0;
        CDB_data_in = '0; CDB_valid_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || CDB_data_valid !== 8'h00 || CDB_data_data !== '0 || CDB_data_addr !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b valid=%h data_nz=%b expected all zero", busy, CDB_data_valid, |CDB_data_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_txn(INST_ADD,  3'd4, READY, 0, 32'd5, READY, 0, 32'd7, 16'h0000, "add_ready");
        run_txn(INST_SUBI, 3'd3, READY, 0, 32'hFFFF_FFFF, 3'd5, 0, 32'h0, 16'hFFFD, "subi_neg");
        run_txn(INST_SUB,  3'd1, READY, 0, 32'd3, READY, 0, 32'd10, 16'h0000, "sub_wrap");
        run_txn(INST_ADDI, 3'd7, READY, 0, 32'h7FFF_FFFF, READY, 0, 32'h0, 16'h0001, "addi_ovf");
    endtask

    task automatic test_snoop();
        run_txn(INST_ADD, 3'd2, 3'd6, 3, 32'd100, READY, 0, 32'd1, 16'h0000, "snoop_j");
        run_txn(INST_SUB, 3'd5, 3'd1, 2, 32'd50, 3'd7, 4, 32'd8, 16'h0000, "snoop_jk");
    endtask

    task automatic test_flush();
        @(negedge clk);
        CDB_inst_inst = {INST_ADD, 4'd1, 4'd2, 4'd3, 16'h0};
        CDB_inst_fu = FU_INDEX'(FU_ID); CDB_inst_RBindex = 3'd5;
        qj = READY; qk = READY; vj = 32'd9; vk = 32'd9;
        @(negedge clk);
        CDB_inst_fu = NO_FU;
`ifndef ADDER_STATION_BYPASS_EN
        @(negedge clk);
`endif
        fu_reset = 1'b1;
        @(negedge clk);
        fu_reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || CDB_data_valid !== 8'h00 || CDB_data_data !== '0) begin
            errors++;
            $display("FAIL flush_exec: busy=%b valid=%h expected 0/00", busy, CDB_data_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (CDB_data_valid !== 8'h00) begin
                errors++;
                $display("FAIL flush_no_result cycle %0d: valid=%h expected 00", i, CDB_data_valid);
            end
        end
        CDB_inst_fu = FU_INDEX'(FU_ID);
        fu_reset = 1'b1;
        @(negedge clk);
        fu_reset = 1'b0;
        CDB_inst_fu = NO_FU;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_vs_issue: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_async_reset();
        run_txn(INST_ADD, 3'd6, READY, 0, 32'd11, READY, 0, 32'd22, 16'h0, "pre_reset");
        #2 reset = 1'b1;
        #1;
        checks++;
        if (CDB_data_valid !== 8'h00 || CDB_data_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%h busy=%b expected 00/0", CDB_data_valid, busy);
        end
        #1 reset = 1'b0;
    endtask

    task automatic test_ignored_issue();
        @(negedge clk);
        CDB_inst_inst = {INST_ADD, 4'd1, 4'd2, 4'd3, 16'h0};
        CDB_inst_fu = FU_INDEX'(FU_ID + 1); CDB_inst_RBindex = 3'd2;
        qj = READY; qk = READY;
        @(negedge clk);
        CDB_inst_inst = {4'hF, 4'd1, 4'd2, 4'd3, 16'h0};
        CDB_inst_fu = FU_INDEX'(FU_ID);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || CDB_data_valid !== 8'h00) begin
                errors++;
                $display("FAIL ignored_issue cycle %0d: busy=%b valid=%h expected 0/00", i, busy, CDB_data_valid);
            end
        end
        CDB_inst_fu = NO_FU;
    endtask

    task automatic test_back_to_back();
        run_txn(INST_ADD, 3'd7, READY, 0, 32'd1, READY, 0, 32'd2, 16'h0, "b2b_first");
        run_txn(INST_SUB, 3'd1, READY, 0, 32'd9, 3'd3, 1, 32'd4, 16'h0, "b2b_second");
    endtask

    task automatic test_random();
        logic [3:0] ops [4];
        ops[0] = INST_ADD; ops[1] = INST_SUB; ops[2] = INST_ADDI; ops[3] = INST_SUBI;
        for (int n = 0; n < 24; n++) begin
            logic [2:0] tj, tk;
            tj = ($urandom_range(0, 1) == 0) ? READY : 3'($urandom_range(1, 7));
            tk = ($urandom_range(0, 1) == 0) ? READY : 3'($urandom_range(1, 7));
            if (tk == tj) tk = READY;
            run_txn(ops[$urandom_range(0, 3)], 3'($urandom_range(1, 7)),
                    tj, $urandom_range(1, 4), $urandom,
                    tk, $urandom_range(1, 4), $urandom,
                    16'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snoop();
        test_flush();
        test_async_reset();
        test_ignored_issue();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
